// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: circular capture of pipeline probe channels with pre/post-trigger
// history, freeze after a programmable post-trigger window, and a registered read port.
module pipe_trace_buffer #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = NUM_CH*(DATA_W+1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic                     trig_i,
  input  logic [AW:0]              post_count_i,
  input  logic                     rd_en_i,
  input  logic [AW-1:0]            rd_addr_i,
  output logic [EW-1:0]            rd_data_o,
  output logic                     rd_valid_o,
  output logic [1:0]               state_o,
  output logic                     done_o,
  output logic [AW-1:0]            wr_ptr_o,
  output logic [AW-1:0]            trig_ptr_o,
  output logic                     wrapped_o,
  output logic [AW:0]              sample_count_o
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d, cnt_q, cnt_d, post_sat;
  logic [AW:0] sc_q, sc_d;
  logic wrapped_q, wrapped_d, rd_valid_q, we, start, trig_hit;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] wr_ent, rd_data_q;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
    assign wr_ent[k*(DATA_W+1) +: DATA_W+1] = {ch_valid_i[k], ch_data_i[k*DATA_W +: DATA_W]};
  end
  // DEPTH-1 is all ones, so any request >= DEPTH has the MSB set and clamps to '1
  assign post_sat = post_count_i[AW] ? '1 : post_count_i[AW-1:0];
  always_comb begin
    state_d = state_q;
    start = 1'b0;
    we = 1'b0;
    if (stop_i) state_d = IDLE;
    else begin
      case (state_q)
        IDLE, DONE: begin
          start = arm_i;
          state_d = arm_i ? ARMED : state_q;
        end
        ARMED: begin
          we = 1'b1;
          if (trig_i) state_d = (post_sat == '0) ? DONE : POST;
        end
        POST: begin
          we = 1'b1;
          if (cnt_q == AW'(1)) state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    trig_hit = we & (state_q == ARMED) & trig_i;
    wr_ptr_d = start ? '0 : we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    wrapped_d = start ? 1'b0 : wrapped_q | (we & (&wr_ptr_q));
    sc_d = start ? '0 : (we & ~sc_q[AW]) ? sc_q + 1'b1 : sc_q;
    trig_ptr_d = start ? '0 : trig_hit ? wr_ptr_q : trig_ptr_q;
    cnt_d = trig_hit ? post_sat : (we && state_q == POST) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      trig_ptr_q <= '0;
      cnt_q <= '0;
      sc_q <= '0;
      wrapped_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      cnt_q <= cnt_d;
      sc_q <= sc_d;
      wrapped_q <= wrapped_d;
      rd_valid_q <= rd_en_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end
  end
  // trace memory is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_ptr_q] <= wr_ent;
  end
  assign rd_data_o = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign state_o = state_q;
  assign done_o = (state_q == DONE);
  assign wr_ptr_o = wr_ptr_q;
  assign trig_ptr_o = trig_ptr_q;
  assign wrapped_o = wrapped_q;
  assign sample_count_o = sc_q;
endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Parametrised, synthesizable trace buffer that captures per-stage snapshots from the MIPS pipeline (IF/ID, ID/EXE, EXE/MEM, MEM/WB registers or any other probe points) into a circular on-chip memory. It arms on command, records pre-trigger history continuously, freezes after a programmable number of post-trigger samples, and exposes a synchronous read port for readout. It replaces ad-hoc `$monitor` tracing with a block that also works in emulation and silicon.

## Interface
- NUM_CH, 4, number of probe channels (1..8)
- DATA_W, 32, width of each channel's data
- DEPTH, 16, trace entries; power of two, >= 4
- AW, $clog2(DEPTH), address width (derived, not overridden)

- clk  in  1  capture and read clock
- rst  in  1  asynchronous, active-low reset
- ch_data  in  NUM_CH*DATA_W  probe data; channel k is bits [k*DATA_W +: DATA_W]
- ch_valid  in  NUM_CH  per-channel qualifier, stored alongside data
- arm  in  1  start a new capture (sampled per cycle)
- stop  in  1  abort capture, return to IDLE
- trig  in  1  trigger qualifier (level)
- post_count  in  AW+1  post-trigger samples, latched at trigger
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  NUM_CH*(DATA_W+1)  entry; per channel {valid, data}, channel k at [k*(DATA_W+1) +: DATA_W+1]
- rd_valid  out  1  rd_data valid
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- done  out  1  high in DONE
- wr_ptr  out  AW  next write address
- trig_ptr  out  AW  address of trigger sample
- wrapped  out  1  buffer has wrapped this capture
- sample_count  out  AW+1  entries written this capture, saturating at DEPTH

## Operation
- Reset (rst low, asynchronous): state IDLE; wr_ptr, trig_ptr, wrapped, sample_count, done, rd_valid, rd_data = 0. Memory contents undefined after power-up; not cleared by reset.
- IDLE: no writes. arm -> ARMED; on the same edge wr_ptr, wrapped, sample_count, trig_ptr cleared.
- ARMED: every cycle writes {ch_valid, ch_data} at wr_ptr; wr_ptr += 1 modulo DEPTH; wrapped set when wr_ptr wraps DEPTH-1 -> 0; sample_count += 1 saturating at DEPTH.
- trig high in ARMED: that cycle's sample is written (the trigger sample); trig_ptr <= wr_ptr; post counter <= min(post_count, DEPTH-1). Counter 0 -> DONE, else POST.
- POST: writes as in ARMED; counter decrements per write; write with counter == 1 is last -> DONE. trig ignored.
- DONE: no writes; memory frozen. arm -> ARMED (new capture, same clearing as from IDLE).
- arm in ARMED or POST: ignored.
- stop in any state: -> IDLE, no write that cycle; pointers and memory retained. stop and arm together: stop wins.
- arm and trig same cycle in IDLE/DONE: only arm acts; trig not seen until ARMED.
- Oldest valid entry: wr_ptr if wrapped, else 0. Saturating post_count at DEPTH-1 guarantees the trigger sample is never overwritten.
- Reads: legal in any state. Same-address read and write in one cycle returns the old contents.

## Timing
- Capture: inputs sampled at the rising edge on which state is ARMED/POST; no input-to-memory latency beyond that edge.
- arm asserted edge N -> state = ARMED after N; first sample written at edge N+1.
- Trigger at edge T with post_count = P (P <= DEPTH-1): last sample at edge T+P; state = DONE and done = 1 after edge T+P.
- Read: rd_en at edge R -> rd_data and rd_valid = 1 after edge R; rd_valid drops after the next edge without rd_en; rd_data holds its last value.
- All outputs registered; no combinational input-to-output paths.

## Test plan
- Reset mid-POST: rst low asynchronously -> state 0, done 0, wr_ptr 0, sample_count 0, rd_valid 0 immediately, without waiting for clk.
- ch0 data = capture index (0,1,2,...); arm, trig on 6th sample, post_count 3 -> trig_ptr 5, wr_ptr 9, sample_count 9, wrapped 0, done 1; entries 0..8 hold 0..8.
- Wrap: trig on 21st sample, post_count 4 -> trig_ptr 4, wr_ptr 9, wrapped 1, sample_count 16; oldest entry at address 9 holds 9, address 4 holds 20.
- Saturation: post_count 20, DEPTH 16 -> exactly 15 post samples; done one edge after the 15th; trigger entry intact.
- stop at 2nd POST cycle -> state IDLE, done 0, no further writes; reading address trig_ptr still returns the trigger sample with rd_valid one edge after rd_en. arm with stop -> remains IDLE.
- Readback while ARMED: rd_addr = wr_ptr on write edge -> old data returned; ch_valid = 4'b1010 captured -> valid bits of channels 1 and 3 read back 1, channels 0 and 2 read back 0.
